// File: rtl/core_pkg.sv
// Shared fetch-path types: sequencer states, pc_sel encodings and RVC detection.
// Combinational definitions only; no latency and no backpressure.
package core_pkg;

   typedef enum logic [2:0] {
      FS_IDLE  = 3'd0,
      FS_REQ   = 3'd1,
      FS_WAIT  = 3'd2,
      FS_OUT   = 3'd3,
      FS_DRAIN = 3'd4
   } fetch_state_t;

   localparam logic [1:0] PC_SEL_PLUS2 = 2'd0;
   localparam logic [1:0] PC_SEL_PLUS4 = 2'd1;
   localparam logic [1:0] PC_SEL_LOAD  = 2'd2;

   // Only the two low opcode bits decide the RVC quadrant.
   function automatic logic is_compressed(input logic [1:0] instr_lsb);
      return instr_lsb != 2'b11;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry holding register between fetch and decode; loads in 1 cycle.
// Contents stay stable while o_vld=1 and i_rdy=0; i_flush drops the entry.
module fetch_buffer
   import core_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [31:0]      i_load_dat,
   input  logic [WIDTH-1:0] i_load_pc,
   input  logic             i_flush,
   input  logic             i_rdy,
   output logic             o_vld,
   output logic [31:0]      o_dat,
   output logic [WIDTH-1:0] o_pc
);

   logic             r_vld;
   logic [31:0]      r_dat;
   logic [WIDTH-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= 1'b0;
         r_dat <= '0;
         r_pc  <= '0;
      end else if (i_load) begin
         r_vld <= 1'b1;
         r_dat <= i_load_dat;
         r_pc  <= i_load_pc;
      end else if (i_flush || (r_vld && i_rdy)) begin
         r_vld <= 1'b0;
      end
   end

   assign o_vld = r_vld;
   assign o_dat = r_dat;
   assign o_pc  = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control: steers program_counter and runs one imem transaction at a time.
// instr_valid 3 cycles after leaving IDLE; holds the buffered instruction until instr_ready.
module fetch_sequencer
   import core_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] pc_in,
   output logic [1:0]       pc_sel,
   output logic [WIDTH-1:0] pc_target,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic             instr_valid,
   output logic [31:0]      instr_data,
   output logic [WIDTH-1:0] instr_pc,
   input  logic             instr_ready,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   output logic             busy
);

   localparam logic [WIDTH-1:0] LSB_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   fetch_state_t w_resume;
   logic         w_capture;
   logic         w_flush;

   always_ff @(posedge clk) begin
      if (rst) r_state <= FS_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Where a finished transaction goes: keep fetching only while enabled.
   assign w_resume = en ? FS_REQ : FS_IDLE;

   always_comb begin
      w_state_nxt = r_state;
      pc_sel      = PC_SEL_LOAD;
      pc_target   = pc_in;
      imem_req    = 1'b0;
      w_capture   = 1'b0;
      w_flush     = 1'b0;
      if (rst) begin
         pc_target   = RESET_PC;
         w_state_nxt = FS_IDLE;
      end else begin
         if (redirect_valid) pc_target = redirect_target & LSB_MASK;
         case (r_state)
            FS_IDLE: begin
               if (en && !redirect_valid) w_state_nxt = FS_REQ;
            end
            FS_REQ: begin
               imem_req = !redirect_valid;
               if (imem_gnt)  w_state_nxt = redirect_valid ? FS_DRAIN : FS_WAIT;
               else if (!en)  w_state_nxt = FS_IDLE;
            end
            FS_WAIT: begin
               if (imem_rvalid) begin
                  if (redirect_valid) begin
                     w_state_nxt = w_resume;
                  end else begin
                     w_capture   = 1'b1;
                     pc_sel      = is_compressed(imem_rdata[1:0]) ? PC_SEL_PLUS2 : PC_SEL_PLUS4;
                     w_state_nxt = FS_OUT;
                  end
               end else if (redirect_valid) begin
                  w_state_nxt = FS_DRAIN;
               end
            end
            FS_OUT: begin
               if (redirect_valid) begin
                  w_flush     = 1'b1;
                  w_state_nxt = w_resume;
               end else if (instr_ready) begin
                  w_state_nxt = w_resume;
               end
            end
            FS_DRAIN: begin
               if (imem_rvalid) w_state_nxt = w_resume;
            end
            default: w_state_nxt = FS_IDLE;
         endcase
      end
   end

   assign imem_addr = pc_in;
   assign busy      = (r_state != FS_IDLE);

   fetch_buffer #(.WIDTH(WIDTH)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_capture),
      .i_load_dat (imem_rdata),
      .i_load_pc  (pc_in),
      .i_flush    (w_flush),
      .i_rdy      (instr_ready),
      .o_vld      (instr_valid),
      .o_dat      (instr_data),
      .o_pc       (instr_pc)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural program_counter.
module tb_fetch_sequencer;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [31:0] pc;
   logic [1:0]  pc_sel;
   logic [31:0] pc_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt, imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr_data, instr_pc;
   logic        instr_ready, redirect_valid;
   logic [31:0] redirect_target;
   logic        busy;

   int vectors = 0;
   int errors  = 0;

   fetch_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .pc_in           (pc),
      .pc_sel          (pc_sel),
      .pc_target       (pc_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .instr_valid     (instr_valid),
      .instr_data      (instr_data),
      .instr_pc        (instr_pc),
      .instr_ready     (instr_ready),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // External program counter: all PC arithmetic lives here, not in the DUT.
   always @(posedge clk) begin
      case (pc_sel)
         2'd0:    pc <= pc + 32'd2;
         2'd1:    pc <= pc + 32'd4;
         default: pc <= pc_target;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; pc = 32'h1234_5670;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      #1;
      chk("rst_pc_sel", {30'd0, pc_sel}, 32'd2);
      chk("rst_pc_target", pc_target, 32'h0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      nxt();
      nxt();
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_data", instr_data, 32'h0);
      chk("rst_ipc", instr_pc, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_pc_loaded", pc, 32'h0);

      // c0 IDLE -> REQ
      rst = 1'b0; en = 1'b1; #1;
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      chk("idle_hold_sel", {30'd0, pc_sel}, 32'd2);
      nxt();
      // c1 REQ, granted at once
      imem_gnt = 1'b1; #1;
      chk("req1", {31'd0, imem_req}, 32'd1);
      chk("req1_addr", imem_addr, 32'h0);
      nxt();
      // c2 WAIT, 32-bit instruction
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; #1;
      chk("wait1_sel_plus4", {30'd0, pc_sel}, 32'd1);
      chk("wait1_req", {31'd0, imem_req}, 32'd0);
      nxt();
      // c3 OUT: valid three cycles after leaving IDLE
      imem_rvalid = 1'b0; instr_ready = 1'b1; #1;
      chk("out1_valid", {31'd0, instr_valid}, 32'd1);
      chk("out1_data", instr_data, 32'h0000_0013);
      chk("out1_ipc", instr_pc, 32'h0);
      chk("out1_pc_adv", pc, 32'h4);
      nxt();
      // c4 REQ at pc 4
      instr_ready = 1'b0; imem_gnt = 1'b1; #1;
      chk("req2_valid_clr", {31'd0, instr_valid}, 32'd0);
      chk("req2", {31'd0, imem_req}, 32'd1);
      chk("req2_addr", imem_addr, 32'h4);
      nxt();
      // c5 WAIT, compressed instruction
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_4501; #1;
      chk("wait2_sel_plus2", {30'd0, pc_sel}, 32'd0);
      nxt();
      // c6..c9 OUT with decode stalled
      imem_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_data", instr_data, 32'h0000_4501);
         chk("stall_ipc", instr_pc, 32'h4);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         chk("stall_sel", {30'd0, pc_sel}, 32'd2);
         chk("stall_target", pc_target, 32'h6);
         nxt();
      end
      // c10 accept
      instr_ready = 1'b1; #1;
      chk("acc_valid", {31'd0, instr_valid}, 32'd1);
      nxt();
      // c11 REQ at pc 6
      instr_ready = 1'b0; imem_gnt = 1'b1; #1;
      chk("req3_addr", imem_addr, 32'h6);
      chk("req3", {31'd0, imem_req}, 32'd1);
      nxt();
      // c12 WAIT, redirect before response
      imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h101; #1;
      chk("redir_wait_sel", {30'd0, pc_sel}, 32'd2);
      chk("redir_wait_target", pc_target, 32'h100);
      chk("redir_wait_req", {31'd0, imem_req}, 32'd0);
      nxt();
      // c13 DRAIN
      redirect_valid = 1'b0; #1;
      chk("drain_busy", {31'd0, busy}, 32'd1);
      chk("drain_req", {31'd0, imem_req}, 32'd0);
      chk("drain_pc", pc, 32'h100);
      nxt();
      // c14 stale response arrives
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
      chk("drain_hold_sel", {30'd0, pc_sel}, 32'd2);
      chk("drain_hold_target", pc_target, 32'h100);
      nxt();
      // c15 REQ at redirect target, stale data discarded
      imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
      chk("post_drain_valid", {31'd0, instr_valid}, 32'd0);
      chk("post_drain_data", instr_data, 32'h0000_4501);
      chk("post_drain_addr", imem_addr, 32'h100);
      chk("post_drain_req", {31'd0, imem_req}, 32'd1);
      nxt();
      // c16 WAIT: redirect coincident with rvalid
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
      redirect_valid = 1'b1; redirect_target = 32'h200; #1;
      chk("redir_rv_sel", {30'd0, pc_sel}, 32'd2);
      chk("redir_rv_target", pc_target, 32'h200);
      nxt();
      // c17 REQ at 0x200
      imem_rvalid = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b1; #1;
      chk("redir_rv_valid", {31'd0, instr_valid}, 32'd0);
      chk("redir_rv_addr", imem_addr, 32'h200);
      chk("redir_rv_req", {31'd0, imem_req}, 32'd1);
      nxt();
      // c18 WAIT
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0297; #1;
      chk("wait4_sel", {30'd0, pc_sel}, 32'd1);
      nxt();
      // c19 OUT: redirect together with instr_ready
      imem_rvalid = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h300; #1;
      chk("out4_ipc", instr_pc, 32'h200);
      chk("redir_out_sel", {30'd0, pc_sel}, 32'd2);
      chk("redir_out_target", pc_target, 32'h300);
      nxt();
      // c20 REQ at 0x300, not 0x204
      instr_ready = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b1; #1;
      chk("redir_out_valid", {31'd0, instr_valid}, 32'd0);
      chk("redir_out_addr", imem_addr, 32'h300);
      nxt();
      // c21 WAIT: reset mid-transaction
      imem_gnt = 1'b0; rst = 1'b1; #1;
      chk("rst_wait_sel", {30'd0, pc_sel}, 32'd2);
      chk("rst_wait_target", pc_target, 32'h0);
      nxt();
      // c22 IDLE: late response must be ignored
      rst = 1'b0; en = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; #1;
      chk("late_busy", {31'd0, busy}, 32'd0);
      chk("late_req", {31'd0, imem_req}, 32'd0);
      chk("late_pc", pc, 32'h0);
      chk("late_sel", {30'd0, pc_sel}, 32'd2);
      nxt();
      // c23
      imem_rvalid = 1'b0; #1;
      chk("late_valid", {31'd0, instr_valid}, 32'd0);
      chk("late_data", instr_data, 32'h0);
      chk("late_busy2", {31'd0, busy}, 32'd0);
      en = 1'b1;
      nxt();
      // c24 REQ without grant, en drops
      en = 1'b0; #1;
      chk("en_off_req", {31'd0, imem_req}, 32'd1);
      chk("en_off_addr", imem_addr, 32'h0);
      nxt();
      // c25 IDLE
      #1;
      chk("en_off_idle_req", {31'd0, imem_req}, 32'd0);
      chk("en_off_idle_busy", {31'd0, busy}, 32'd0);
      en = 1'b1;
      nxt();
      // c26 REQ: redirect without grant drops req, stays REQ
      redirect_valid = 1'b1; redirect_target = 32'h41; #1;
      chk("redir_req_req", {31'd0, imem_req}, 32'd0);
      chk("redir_req_target", pc_target, 32'h40);
      nxt();
      // c27
      redirect_valid = 1'b0; #1;
      chk("redir_req_again", {31'd0, imem_req}, 32'd1);
      chk("redir_req_addr", imem_addr, 32'h40);
      chk("redir_req_busy", {31'd0, busy}, 32'd1);
      en = 1'b0;
      nxt();
      #1;
      chk("final_busy", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the program counter in the single-cycle RV32IC core: drives pc_sel and the load target into program_counter, and runs the instruction-memory request/grant/response handshake.
- Hands each fetched instruction and its PC to decode over a valid/ready handshake.
- Sequential advance is pc+2 for compressed instructions (imem_rdata[1:0] != 2'b11) and pc+4 otherwise.
- Accepts branch/jump redirects at any time and discards stale responses.

Parameters:
WIDTH, 32, PC/address width
RESET_PC, 32'h0000_0000, PC value loaded after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  fetch enable; 0 stops fetching at the next transaction boundary
pc_in  in  WIDTH  current PC from program_counter
pc_sel  out  2  0 = pc+2, 1 = pc+4, 2 = load pc_target
pc_target  out  WIDTH  load value for program_counter
imem_req  out  1  fetch request
imem_addr  out  WIDTH  fetch address (= pc_in)
imem_gnt  in  1  request accepted
imem_rvalid  in  1  response data valid
imem_rdata  in  32  fetched word
instr_valid  out  1  instruction available to decode
instr_data  out  32  buffered instruction
instr_pc  out  WIDTH  PC of the buffered instruction
instr_ready  in  1  decode accepts the instruction
redirect_valid  in  1  branch/jump taken
redirect_target  in  WIDTH  redirect PC
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, REQ, WAIT, OUT, DRAIN. All registers update on the rising clk edge.
- Reset (rst=1):
  - state=IDLE; imem_req=0; instr_valid=0; instr_data=0; instr_pc=0.
  - pc_sel=2 and pc_target=RESET_PC, so the PC loads RESET_PC.
  - A reset in any state aborts any outstanding transaction. No response is accepted after reset until a new request is granted.
- Hold: the PC has no hold encoding. Every cycle without an advance or redirect drives pc_sel=2 with pc_target=pc_in.
- IDLE: en=1 -> REQ.
- REQ:
  - imem_req=1, imem_addr=pc_in. Address is stable while req=1 and gnt=0.
  - gnt -> WAIT.
  - en=0 with gnt=0 -> IDLE (req drops).
- WAIT:
  - imem_rvalid=1 -> capture imem_rdata into instr_data and pc_in into instr_pc.
  - In the same cycle drive pc_sel=0 if rdata[1:0]!=2'b11, else pc_sel=1.
  - Next state is OUT.
- OUT:
  - instr_valid=1; data and PC are held stable until accepted.
  - instr_ready=1 -> instr_valid=0 next cycle, then REQ if en=1, else IDLE.
- Latency: grant in the first REQ cycle plus rvalid in the first WAIT cycle gives instr_valid 3 cycles after leaving IDLE. The next request is issued the cycle after instr_ready.
- Redirect (redirect_valid=1) has priority over every other PC update:
  - It always drives pc_sel=2 and pc_target={redirect_target[WIDTH-1:1],1'b0}; bit 0 is forced to 0.
  - REQ, gnt=0: req drops for this cycle; stay REQ.
  - REQ with gnt=1, or WAIT with rvalid=0: go to DRAIN.
  - WAIT with rvalid=1: data is dropped, no sequential advance -> REQ.
  - OUT: instr_valid cleared next cycle, even if instr_ready=1 in the same cycle -> REQ.
  - IDLE: PC loaded; stay IDLE.
- DRAIN: imem_req=0; wait for rvalid, discard the data, hold the PC -> REQ (en=1) or IDLE (en=0).
- en=0 in WAIT/OUT/DRAIN: the current transaction completes; stop at IDLE.
- At most one outstanding imem transaction at any time.
- All PC arithmetic stays in program_counter; this block never adds.

Decomposition:
- Shared package (core_pkg):
  - State enum FS_IDLE/FS_REQ/FS_WAIT/FS_OUT/FS_DRAIN.
  - PC_SEL_PLUS2=2'd0, PC_SEL_PLUS4=2'd1, PC_SEL_LOAD=2'd2.
  - Function is_compressed(instr) = instr[1:0]!=2'b11.
- One sub-module is natural: fetch_buffer, the single-entry instr_data/instr_pc holding register with valid/ready logic.

Test Plan:
- Reset then en=1, 1-cycle gnt/rvalid, rdata=32'h0000_0013 -> instr_valid at cycle 3, instr_pc=0x0, pc_sel=1, next imem_addr=0x4.
- rdata=32'h0000_4501 (compressed) at pc 0x4 -> pc_sel=0, next imem_addr=0x6.
- Downstream stall: instr_ready=0 for 4 cycles -> instr_data/instr_pc stable, no imem_req, pc_sel=2 with target=pc_in every cycle.
- Redirect to 0x101 in WAIT, rvalid 2 cycles later with 32'hDEAD_BEEF -> pc_target=0x100, DRAIN, data never appears on instr_data, next imem_addr=0x100.
- Redirect coincident with rvalid, and separately with instr_ready in OUT -> no sequential advance, instr_valid=0 next cycle, PC=target.
- rst=1 asserted in WAIT, then a late rvalid -> IDLE, PC=RESET_PC, instr_valid stays 0; en=0 in REQ without gnt -> IDLE, imem_req=0.
